// File: rtl/roce_wr_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : roce_wr_req_arbiter_if
// Description : Bundle of the per-port work-request inputs, the merged
//               work-request output, completion feedback and outstanding-count
//               status used by roce_wr_req_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface roce_wr_req_arbiter_if #(
  parameter int NUM_PORTS       = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ID_WIDTH        = $clog2(NUM_PORTS),
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
);
  logic [NUM_PORTS-1:0]           s_wr_req_valid;
  logic [NUM_PORTS-1:0]           s_wr_req_ready;
  logic [NUM_PORTS*24-1:0]        s_wr_req_loc_qp;
  logic [NUM_PORTS*32-1:0]        s_wr_req_dma_length;
  logic [NUM_PORTS*64-1:0]        s_wr_req_addr_offset;
  logic [NUM_PORTS-1:0]           s_wr_req_is_immediate;
  logic [NUM_PORTS-1:0]           s_wr_req_tx_type;

  logic                           m_wr_req_valid;
  logic                           m_wr_req_ready;
  logic [23:0]                    m_wr_req_loc_qp;
  logic [31:0]                    m_wr_req_dma_length;
  logic [63:0]                    m_wr_req_addr_offset;
  logic                           m_wr_req_is_immediate;
  logic                           m_wr_req_tx_type;
  logic [ID_WIDTH-1:0]            m_wr_req_id;

  logic                           s_wr_done_valid;
  logic [ID_WIDTH-1:0]            s_wr_done_id;

  logic [NUM_PORTS*CNT_WIDTH-1:0] outstanding_cnt;

  // Arbiter side
  modport slave (
    input  s_wr_req_valid, s_wr_req_loc_qp, s_wr_req_dma_length,
           s_wr_req_addr_offset, s_wr_req_is_immediate, s_wr_req_tx_type,
           m_wr_req_ready, s_wr_done_valid, s_wr_done_id,
    output s_wr_req_ready, m_wr_req_valid, m_wr_req_loc_qp, m_wr_req_dma_length,
           m_wr_req_addr_offset, m_wr_req_is_immediate, m_wr_req_tx_type,
           m_wr_req_id, outstanding_cnt
  );

  // Requester / work-queue side
  modport master (
    output s_wr_req_valid, s_wr_req_loc_qp, s_wr_req_dma_length,
           s_wr_req_addr_offset, s_wr_req_is_immediate, s_wr_req_tx_type,
           m_wr_req_ready, s_wr_done_valid, s_wr_done_id,
    input  s_wr_req_ready, m_wr_req_valid, m_wr_req_loc_qp, m_wr_req_dma_length,
           m_wr_req_addr_offset, m_wr_req_is_immediate, m_wr_req_tx_type,
           m_wr_req_id, outstanding_cnt
  );
endinterface
`default_nettype wire

// File: rtl/roce_wr_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : roce_wr_req_arbiter
// Description : Round-robin merge of NUM_PORTS work-request streams into one
//               registered stream tagged with the source port, with a per-port
//               cap of MAX_OUTSTANDING un-completed requests.
// Revision    : 1.0 - initial release
// ============================================================================
module roce_wr_req_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ID_WIDTH        = $clog2(NUM_PORTS),
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  roce_wr_req_arbiter_if.slave bus
);

  logic [CNT_WIDTH-1:0] r_cnt [NUM_PORTS];
  logic [ID_WIDTH-1:0]  r_last_grant;
  logic                 r_valid;
  logic [23:0]          r_loc_qp;
  logic [31:0]          r_dma_length;
  logic [63:0]          r_addr_offset;
  logic                 r_is_immediate;
  logic                 r_tx_type;
  logic [ID_WIDTH-1:0]  r_id;

  logic [NUM_PORTS-1:0] w_eligible;
  logic [NUM_PORTS-1:0] w_ready;
  logic                 w_load;
  logic                 w_grant_any;
  logic [ID_WIDTH-1:0]  w_grant_idx;
  logic [ID_WIDTH-1:0]  w_scan;
  logic [23:0]          w_sel_loc_qp;
  logic [31:0]          w_sel_dma_length;
  logic [63:0]          w_sel_addr_offset;
  logic                 w_sel_is_immediate;
  logic                 w_sel_tx_type;

  // The output register may take a new request when empty or being drained.
  assign w_load = !r_valid || bus.m_wr_req_ready;

  // Round-robin scan starting just after the last granted port.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_scan      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_scan = ID_WIDTH'((int'(r_last_grant) + k) % NUM_PORTS);
      if (!w_grant_any && w_eligible[w_scan]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_scan;
      end
    end
  end

  assign w_ready            = (w_load && w_grant_any) ? (NUM_PORTS'(1) << w_grant_idx) : '0;
  assign bus.s_wr_req_ready = w_ready;

  // Select the granted port's request fields.
  always_comb begin
    w_sel_loc_qp       = '0;
    w_sel_dma_length   = '0;
    w_sel_addr_offset  = '0;
    w_sel_is_immediate = 1'b0;
    w_sel_tx_type      = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_grant_idx == ID_WIDTH'(p)) begin
        w_sel_loc_qp       = bus.s_wr_req_loc_qp[p*24 +: 24];
        w_sel_dma_length   = bus.s_wr_req_dma_length[p*32 +: 32];
        w_sel_addr_offset  = bus.s_wr_req_addr_offset[p*64 +: 64];
        w_sel_is_immediate = bus.s_wr_req_is_immediate[p];
        w_sel_tx_type      = bus.s_wr_req_tx_type[p];
      end
    end
  end

  // Output stage: capture a grant, go idle when nothing is eligible, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid        <= 1'b0;
      r_loc_qp       <= '0;
      r_dma_length   <= '0;
      r_addr_offset  <= '0;
      r_is_immediate <= 1'b0;
      r_tx_type      <= 1'b0;
      r_id           <= '0;
      r_last_grant   <= ID_WIDTH'(NUM_PORTS - 1);
    end else if (w_load) begin
      r_valid <= w_grant_any;
      if (w_grant_any) begin
        r_loc_qp       <= w_sel_loc_qp;
        r_dma_length   <= w_sel_dma_length;
        r_addr_offset  <= w_sel_addr_offset;
        r_is_immediate <= w_sel_is_immediate;
        r_tx_type      <= w_sel_tx_type;
        r_id           <= w_grant_idx;
        r_last_grant   <= w_grant_idx;
      end
    end
  end

  assign bus.m_wr_req_valid        = r_valid;
  assign bus.m_wr_req_loc_qp       = r_loc_qp;
  assign bus.m_wr_req_dma_length   = r_dma_length;
  assign bus.m_wr_req_addr_offset  = r_addr_offset;
  assign bus.m_wr_req_is_immediate = r_is_immediate;
  assign bus.m_wr_req_tx_type      = r_tx_type;
  assign bus.m_wr_req_id           = r_id;

  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      logic w_inc;
      logic w_dec;

      // Eligibility looks only at the registered count; a same-cycle completion helps next cycle.
      assign w_eligible[i] = bus.s_wr_req_valid[i] && (r_cnt[i] < CNT_WIDTH'(MAX_OUTSTANDING));
      assign w_inc = bus.s_wr_req_valid[i] && w_ready[i];
      // Completions for an idle port or an unused id never match and are dropped.
      assign w_dec = bus.s_wr_done_valid && (bus.s_wr_done_id == ID_WIDTH'(i)) && (r_cnt[i] != '0);

      // Per-port in-flight counter.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt[i] <= '0;
        end else if (w_inc && !w_dec) begin
          r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
        end else if (!w_inc && w_dec) begin
          r_cnt[i] <= r_cnt[i] - CNT_WIDTH'(1);
        end
      end

      assign bus.outstanding_cnt[i*CNT_WIDTH +: CNT_WIDTH] = r_cnt[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_roce_wr_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_roce_wr_req_arbiter
// Description : Scoreboard bench for roce_wr_req_arbiter. Instance 0 is the
//               4-port / limit-8 configuration, instance 1 a 3-port / limit-3
//               configuration where completion id 3 is out of range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_roce_wr_req_arbiter;

  typedef struct packed {
    logic [23:0] qp;
    logic [31:0] len;
    logic [63:0] off;
    logic        imm;
    logic        tt;
    logic [1:0]  id;
  } exp_t;

  localparam int NP   [2] = '{4, 3};
  localparam int MAXO [2] = '{8, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Stimulus, indexed [instance][port]
  logic [3:0]  vld  [2];
  logic [23:0] qp   [2][4];
  logic [31:0] len  [2][4];
  logic [63:0] off  [2][4];
  logic [3:0]  imm  [2];
  logic [3:0]  tt   [2];
  logic        mrdy [2];
  logic        dv   [2];
  logic [1:0]  did  [2];

  // Observed DUT outputs
  logic [3:0]  rdy  [2];
  logic        mv   [2];
  exp_t        mo   [2];
  logic [3:0]  ocnt [2][4];

  // Reference model state
  int   mcnt [2][4];
  int   last [2];
  exp_t q    [2][$];

  int  checks = 0;
  int  errors = 0;
  logic mon_en = 1'b0;

  roce_wr_req_arbiter_if #(.NUM_PORTS(4), .MAX_OUTSTANDING(8)) bus4 ();
  roce_wr_req_arbiter_if #(.NUM_PORTS(3), .MAX_OUTSTANDING(3)) bus3 ();

  roce_wr_req_arbiter #(.NUM_PORTS(4), .MAX_OUTSTANDING(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  roce_wr_req_arbiter #(.NUM_PORTS(3), .MAX_OUTSTANDING(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  always_comb begin
    bus4.s_wr_req_valid        = vld[0];
    bus4.s_wr_req_is_immediate = imm[0];
    bus4.s_wr_req_tx_type      = tt[0];
    bus4.m_wr_req_ready        = mrdy[0];
    bus4.s_wr_done_valid       = dv[0];
    bus4.s_wr_done_id          = did[0];
    bus4.s_wr_req_loc_qp       = {qp[0][3], qp[0][2], qp[0][1], qp[0][0]};
    bus4.s_wr_req_dma_length   = {len[0][3], len[0][2], len[0][1], len[0][0]};
    bus4.s_wr_req_addr_offset  = {off[0][3], off[0][2], off[0][1], off[0][0]};
    bus3.s_wr_req_valid        = vld[1][2:0];
    bus3.s_wr_req_is_immediate = imm[1][2:0];
    bus3.s_wr_req_tx_type      = tt[1][2:0];
    bus3.m_wr_req_ready        = mrdy[1];
    bus3.s_wr_done_valid       = dv[1];
    bus3.s_wr_done_id          = did[1];
    bus3.s_wr_req_loc_qp       = {qp[1][2], qp[1][1], qp[1][0]};
    bus3.s_wr_req_dma_length   = {len[1][2], len[1][1], len[1][0]};
    bus3.s_wr_req_addr_offset  = {off[1][2], off[1][1], off[1][0]};
  end

  always_comb begin
    rdy[0] = bus4.s_wr_req_ready;
    rdy[1] = {1'b0, bus3.s_wr_req_ready};
    mv[0]  = bus4.m_wr_req_valid;
    mv[1]  = bus3.m_wr_req_valid;
    mo[0]  = {bus4.m_wr_req_loc_qp, bus4.m_wr_req_dma_length, bus4.m_wr_req_addr_offset,
              bus4.m_wr_req_is_immediate, bus4.m_wr_req_tx_type, bus4.m_wr_req_id};
    mo[1]  = {bus3.m_wr_req_loc_qp, bus3.m_wr_req_dma_length, bus3.m_wr_req_addr_offset,
              bus3.m_wr_req_is_immediate, bus3.m_wr_req_tx_type, bus3.m_wr_req_id};
    for (int p = 0; p < 4; p++) ocnt[0][p] = bus4.outstanding_cnt[p*4 +: 4];
    ocnt[1][0] = {2'b00, bus3.outstanding_cnt[1:0]};
    ocnt[1][1] = {2'b00, bus3.outstanding_cnt[3:2]};
    ocnt[1][2] = {2'b00, bus3.outstanding_cnt[5:4]};
    ocnt[1][3] = 4'd0;
  end

  task automatic chk(input string name, input int d, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0h, expected %0h", name, d, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      last[d] = NP[d] - 1;
      for (int p = 0; p < 4; p++) mcnt[d][p] = 0;
    end
  endtask

  task automatic rand_all(input int d, input int vpct, input int rpct, input int dpct);
    for (int p = 0; p < 4; p++) begin
      vld[d][p] = (p < NP[d]) && ($urandom_range(99) < vpct);
      qp[d][p]  = 24'($urandom);
      len[d][p] = $urandom;
      off[d][p] = {$urandom, $urandom};
      imm[d][p] = 1'($urandom);
      tt[d][p]  = 1'($urandom);
    end
    mrdy[d] = ($urandom_range(99) < rpct);
    dv[d]   = ($urandom_range(99) < dpct);
    did[d]  = 2'($urandom);
  endtask

  // Called right after the negedge once inputs are set: checks ready/counts,
  // predicts the grant and advances the model after the monitor has looked.
  task automatic step();
    int g [2];
    bit ld;
    int p;
    for (int d = 0; d < 2; d++)
      if (dv[d] && int'(did[d]) < NP[d] && mcnt[d][did[d]] == 0 && vld[d][did[d]]) dv[d] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d] = -1;
      for (int k = 0; k < NP[d]; k++) chk("outstanding_cnt", d, ocnt[d][k], mcnt[d][k]);
      if (!rst) begin
        ld = (q[d].size() == 0) || mrdy[d];
        if (ld) begin
          for (int k = 1; k <= NP[d]; k++) begin
            p = (last[d] + k) % NP[d];
            if (g[d] < 0 && vld[d][p] && mcnt[d][p] < MAXO[d]) g[d] = p;
          end
        end
        chk("s_wr_req_ready", d, rdy[d], (g[d] >= 0) ? (1 << g[d]) : 0);
      end
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        q[d].delete();
        last[d] = NP[d] - 1;
        for (int k = 0; k < 4; k++) mcnt[d][k] = 0;
      end else begin
        if (g[d] >= 0) begin
          q[d].push_back({qp[d][g[d]], len[d][g[d]], off[d][g[d]], imm[d][g[d]], tt[d][g[d]], 2'(g[d])});
          last[d] = g[d];
        end
        for (int k = 0; k < NP[d]; k++) begin
          if (dv[d] && int'(did[d]) == k && mcnt[d][k] > 0) mcnt[d][k]--;
          if (g[d] == k) mcnt[d][k]++;
        end
      end
    end
  endtask

  // Monitor: the output register must show exactly the oldest unconsumed grant.
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
        chk("m_wr_req_valid", d, mv[d], q[d].size() != 0);
        if (q[d].size() != 0) begin
          chk("m_wr_req_data", d, mo[d], q[d][0]);
          if (mrdy[d]) void'(q[d].pop_front());
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rand_all(d, 0, 0, 0);
      imm[d] = '0;
      tt[d]  = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", d, mv[d], 0);
      chk("reset_data", d, mo[d], 0);
      for (int p = 0; p < NP[d]; p++) chk("reset_cnt", d, ocnt[d][p], 0);
    end
    mon_en = 1'b1;

    // Single request on port 2
    @(negedge clk);
    rst = 1'b0;
    rand_all(0, 0, 100, 0);
    vld[0] = 4'b0100;
    qp[0][2] = 24'h000102; len[0][2] = 32'h1000; off[0][2] = 64'h40;
    rand_all(1, 70, 70, 40);
    step();
    repeat (3) begin
      @(negedge clk); rand_all(0, 0, 100, 0); rand_all(1, 70, 70, 40); step();
    end

    // All ports requesting continuously
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rand_all(0, 100, 100, 0);
      dv[0] = 1'b1; did[0] = 2'(i % 4);
      rand_all(1, 70, 70, 40);
      step();
    end

    // Backpressure for 5 cycles, then release
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rand_all(0, 100, (i < 5) ? 0 : 100, 30);
      rand_all(1, 70, 70, 40);
      step();
    end

    // Drain port counts, then drive port 0 into its limit
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      rand_all(0, 0, 100, 0);
      for (int p = 0; p < 4; p++)
        if (!dv[0] && mcnt[0][p] > 0) begin dv[0] = 1'b1; did[0] = 2'(p); end
      rand_all(1, 70, 70, 40);
      step();
    end
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); rand_all(0, 0, 100, 0); vld[0] = 4'b0001; rand_all(1, 70, 70, 40); step();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rand_all(0, 100, 100, 0); rand_all(1, 70, 70, 40); step();
    end
    @(negedge clk);
    rand_all(0, 100, 100, 0); dv[0] = 1'b1; did[0] = 2'd0;
    rand_all(1, 70, 70, 40);
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rand_all(0, 100, 100, 0); rand_all(1, 70, 70, 40); step();
    end

    // Long random run
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); rand_all(0, 60, 75, 50); rand_all(1, 60, 75, 50); step();
    end

    // Reset in the middle of traffic, then restart
    @(negedge clk);
    rand_all(0, 100, 50, 20); rand_all(1, 100, 50, 20);
    rst = 1'b1;
    step();
    @(negedge clk);
    rst = 1'b0;
    rand_all(0, 100, 100, 0); rand_all(1, 100, 100, 0);
    step();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); rand_all(0, 60, 75, 50); rand_all(1, 60, 75, 50); step();
    end

    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
